hazard_ctrl: RTL and testbench

Parametrised pipeline hazard controller for the RISC core, sitting beside the IF/ID and ID/EX registers and driving PC, IF/ID and instruction-memory enables. Detects load-use hazards with a configurable number of bubble cycles and ignores unused source fields and, optionally, register 0. Adds a full-pipeline freeze on data-memory wait, a flush on a taken branch, and a saturating bubble counter.

---
 rtl/hazard_ctrl_pkg.sv | 47 ++++
 rtl/hazard_ctrl_if.sv | 44 ++++
 rtl/hazard_ctrl_cmp.sv | 40 ++++
 rtl/hazard_ctrl.sv | 136 +++++++++++++
 tb/tb_hazard_ctrl.sv | 477 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the pipeline hazard controller:
//   - state_e        : controller FSM states (RUN, LSTALL)
//   - BUBBLE_CNT_W   : width of the saturating bubble counter
//   - CNT_W          : width of the load-use bubble down-counter
//   - ctrl_t         : the six pipeline control outputs as one packed struct
//   - CTRL_*         : the four legal control output sets
//   - sat_inc        : saturating increment for the bubble counter
// ---------------------------------------------------------------------------
package hazard_pkg;

  localparam int BUBBLE_CNT_W = 16;
  localparam int CNT_W        = 4;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    LSTALL = 1'b1
  } state_e;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic st;
    logic enIW;
    logic ifid_flush;
    logic idex_flush;
  } ctrl_t;

  //                                  pc    ifid  st    enIW  iff   ief
  localparam ctrl_t CTRL_PASS   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam ctrl_t CTRL_STALL  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam ctrl_t CTRL_FLUSH  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [BUBBLE_CNT_W-1:0] sat_inc(input logic [BUBBLE_CNT_W-1:0] v);
    logic [BUBBLE_CNT_W-1:0] r;
    if (v == {BUBBLE_CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(BUBBLE_CNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_if
// Bundle of every pipeline-facing signal of the hazard controller.
//   slave  modport : used by hazard_ctrl (pipeline fields in, enables out)
//   master modport : used by the pipeline side driving the controller
// Pipeline fields : if_id_rn1/2, if_id_use1/2, id_ex_rd, id_ex_memread,
//                   mem_busy, branch_taken
// Controls        : pc_write, ifid_write, st, enIW, ifid_flush, idex_flush
// Status          : bubble_cnt (saturating count of bubble cycles)
// ---------------------------------------------------------------------------
interface hazard_ctrl_if #(
  parameter int RAW = 4
);
  import hazard_pkg::*;

  logic [RAW-1:0]          if_id_rn1;
  logic [RAW-1:0]          if_id_rn2;
  logic                    if_id_use1;
  logic                    if_id_use2;
  logic [RAW-1:0]          id_ex_rd;
  logic                    id_ex_memread;
  logic                    mem_busy;
  logic                    branch_taken;
  logic                    pc_write;
  logic                    ifid_write;
  logic                    st;
  logic                    enIW;
  logic                    ifid_flush;
  logic                    idex_flush;
  logic [BUBBLE_CNT_W-1:0] bubble_cnt;

  modport master (
    output if_id_rn1, if_id_rn2, if_id_use1, if_id_use2,
    output id_ex_rd, id_ex_memread, mem_busy, branch_taken,
    input  pc_write, ifid_write, st, enIW, ifid_flush, idex_flush, bubble_cnt
  );

  modport slave (
    input  if_id_rn1, if_id_rn2, if_id_use1, if_id_use2,
    input  id_ex_rd, id_ex_memread, mem_busy, branch_taken,
    output pc_write, ifid_write, st, enIW, ifid_flush, idex_flush, bubble_cnt
  );

endinterface

// File: rtl/hazard_ctrl_cmp.sv
// ---------------------------------------------------------------------------
// hazard_cmp
// Combinational load-use hazard detector.
//   i_rn1, i_rn2   : source register fields of the instruction in ID
//   i_use1, i_use2 : source field is actually read
//   i_rd           : destination register of the instruction in EX
//   i_memread      : instruction in EX is a load
//   o_hit          : load-use hazard present this cycle
// With ZERO_REG_EN set, register 0 is hardwired and never a hazard.
// ---------------------------------------------------------------------------
module hazard_cmp
  import hazard_pkg::*;
#(
  parameter int RAW         = 4,
  parameter int ZERO_REG_EN = 0
) (
  input  logic [RAW-1:0] i_rn1,
  input  logic [RAW-1:0] i_rn2,
  input  logic           i_use1,
  input  logic           i_use2,
  input  logic [RAW-1:0] i_rd,
  input  logic           i_memread,
  output logic           o_hit
);

  localparam bit ZR = (ZERO_REG_EN != 0);

  logic w_m1;
  logic w_m2;
  logic w_zero;

  // Match each used source field against the load destination.
  always_comb begin
    w_m1   = i_use1 & (i_rn1 == i_rd);
    w_m2   = i_use2 & (i_rn2 == i_rd);
    w_zero = ZR & (i_rd == {RAW{1'b0}});
    o_hit  = i_memread & (w_m1 | w_m2) & ~w_zero;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller: load-use stall with LOAD_STALL bubbles,
// full freeze on data-memory wait, flush on taken branch, saturating
// bubble counter. Controls are combinational from state and inputs so a
// hazard stalls in the same cycle it is seen.
//   clk : core clock
//   rst : synchronous active-high reset (controls forced to PASS)
//   bus : hazard_ctrl_if.slave (pipeline fields in, enables/flushes out)
// Priority each cycle: rst > branch_taken > mem_busy > stall logic.
// ---------------------------------------------------------------------------
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int RAW         = 4,
  parameter int LOAD_STALL  = 1,
  parameter int ZERO_REG_EN = 0
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave bus
);

  // Bubbles still owed after the first one, loaded on entry to LSTALL.
  localparam logic [CNT_W-1:0] LS_M1    = CNT_W'(LOAD_STALL - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam bit               LS_MULTI = (LOAD_STALL > 1);

  state_e                  r_state;
  state_e                  w_state_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic [BUBBLE_CNT_W-1:0] r_bubble_cnt;
  ctrl_t                   w_ctrl;
  logic                    w_hit;

  hazard_cmp #(
    .RAW         (RAW),
    .ZERO_REG_EN (ZERO_REG_EN)
  ) u_cmp (
    .i_rn1     (bus.if_id_rn1),
    .i_rn2     (bus.if_id_rn2),
    .i_use1    (bus.if_id_use1),
    .i_use2    (bus.if_id_use2),
    .i_rd      (bus.id_ex_rd),
    .i_memread (bus.id_ex_memread),
    .o_hit     (w_hit)
  );

  // Next-state, bubble down-counter and control output decode.
  always_comb begin
    w_ctrl      = CTRL_PASS;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (rst) begin
      w_ctrl      = CTRL_PASS;
      w_state_nxt = RUN;
      w_cnt_nxt   = CNT_ZERO;
    end else begin
      case (r_state)
        RUN: begin
          if (bus.branch_taken) begin
            w_ctrl = CTRL_FLUSH;
          end else if (bus.mem_busy) begin
            w_ctrl = CTRL_FREEZE;
          end else if (w_hit) begin
            w_ctrl = CTRL_STALL;
            if (LS_MULTI) begin
              w_state_nxt = LSTALL;
              w_cnt_nxt   = LS_M1;
            end else begin
              w_state_nxt = RUN;
            end
          end else begin
            w_ctrl = CTRL_PASS;
          end
        end
        LSTALL: begin
          if (bus.branch_taken) begin
            w_ctrl      = CTRL_FLUSH;
            w_state_nxt = RUN;
            w_cnt_nxt   = CNT_ZERO;
          end else if (bus.mem_busy) begin
            w_ctrl = CTRL_FREEZE;
          end else begin
            // New hits are ignored here; the owed bubbles already cover them.
            w_ctrl = CTRL_STALL;
            if (r_cnt <= CNT_ONE) begin
              w_state_nxt = RUN;
              w_cnt_nxt   = CNT_ZERO;
            end else begin
              w_cnt_nxt = r_cnt - CNT_ONE;
            end
          end
        end
        default: begin
          w_ctrl      = CTRL_PASS;
          w_state_nxt = RUN;
          w_cnt_nxt   = CNT_ZERO;
        end
      endcase
    end
  end

  // State and down-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_cnt   <= CNT_ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Saturating count of cycles that issued a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bubble_cnt <= {BUBBLE_CNT_W{1'b0}};
    end else if (w_ctrl.st) begin
      r_bubble_cnt <= sat_inc(r_bubble_cnt);
    end else begin
      r_bubble_cnt <= r_bubble_cnt;
    end
  end

  assign bus.pc_write   = w_ctrl.pc_write;
  assign bus.ifid_write = w_ctrl.ifid_write;
  assign bus.st         = w_ctrl.st;
  assign bus.enIW       = w_ctrl.enIW;
  assign bus.ifid_flush = w_ctrl.ifid_flush;
  assign bus.idex_flush = w_ctrl.idex_flush;
  assign bus.bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
// Three controllers share one stimulus stream:
//   dut 0 : LOAD_STALL=1, ZERO_REG_EN=0
//   dut 1 : LOAD_STALL=3, ZERO_REG_EN=0
//   dut 2 : LOAD_STALL=3, ZERO_REG_EN=1
// Inputs change on the falling edge; expectations are queued with the
// stimulus and compared 2 time units later. Control vectors are
// {pc_write, ifid_write, st, enIW, ifid_flush, idex_flush}.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam int RAW = 4;

  localparam logic [5:0] PASS   = 6'b110100;
  localparam logic [5:0] STALL  = 6'b001000;
  localparam logic [5:0] FREEZE = 6'b000000;
  localparam logic [5:0] FLUSH  = 6'b110111;

  typedef struct {
    int          dut;
    bit          is_bc;
    logic [15:0] val;
    string       name;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [RAW-1:0] t_rn1, t_rn2, t_rd;
  logic           t_use1, t_use2, t_mr, t_busy, t_br;
  logic [5:0]     obs_ctrl [3];
  logic [15:0]    obs_bc   [3];

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    hazard_ctrl_if #(.RAW(RAW)) bus ();
    assign bus.if_id_rn1     = t_rn1;
    assign bus.if_id_rn2     = t_rn2;
    assign bus.if_id_use1    = t_use1;
    assign bus.if_id_use2    = t_use2;
    assign bus.id_ex_rd      = t_rd;
    assign bus.id_ex_memread = t_mr;
    assign bus.mem_busy      = t_busy;
    assign bus.branch_taken  = t_br;

    hazard_ctrl #(
      .RAW         (RAW),
      .LOAD_STALL  ((g == 0) ? 1 : 3),
      .ZERO_REG_EN ((g == 2) ? 1 : 0)
    ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    assign obs_ctrl[g] = {bus.pc_write, bus.ifid_write, bus.st, bus.enIW,
                          bus.ifid_flush, bus.idex_flush};
    assign obs_bc[g]   = bus.bubble_cnt;
  end

  task automatic set_in(input logic [RAW-1:0] rd, input logic mr,
                        input logic [RAW-1:0] rn1, input logic u1,
                        input logic [RAW-1:0] rn2, input logic u2,
                        input logic busy, input logic br);
    t_rd = rd; t_mr = mr; t_rn1 = rn1; t_use1 = u1;
    t_rn2 = rn2; t_use2 = u2; t_busy = busy; t_br = br;
  endtask

  task automatic set_idle();
    set_in(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Load to r3 with the ID instruction reading r3 on port 1.
  task automatic set_hit(input logic busy, input logic br);
    set_in(4'd3, 1'b1, 4'd3, 1'b1, 4'd0, 1'b0, busy, br);
  endtask

  task automatic exp_ctrl(input int d, input logic [5:0] v, input string n);
    exp_t e;
    e.dut = d; e.is_bc = 1'b0; e.val = {10'd0, v}; e.name = n;
    exp_q.push_back(e);
  endtask

  task automatic exp_bc(input int d, input logic [15:0] v, input string n);
    exp_t e;
    e.dut = d; e.is_bc = 1'b1; e.val = v; e.name = n;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_rst();
    rst = 1'b1;
    set_idle();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e; logic [15:0] obs;
    for (int c = 0; c < 2; c++) begin
      case (c)
        0: begin
          rst = 1'b1; set_hit(1'b0, 1'b0);
          for (int d = 0; d < 3; d++) exp_ctrl(d, PASS, "rst_forces_pass");
        end
        default: begin
          rst = 1'b0; set_idle();
          for (int d = 0; d < 3; d++) begin
            exp_ctrl(d, PASS, "reset_ctrl");
            exp_bc(d, 16'd0, "reset_bubble_cnt");
          end
        end
      endcase
      #2;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        obs = e.is_bc ? obs_bc[e.dut] : {10'd0, obs_ctrl[e.dut]};
        n_vec++;
        if (obs !== e.val) begin
          n_err++;
          $display("FAIL %s: dut%0d observed %h expected %h", e.name, e.dut, obs, e.val);
        end
      end
      tick();
    end
  endtask

  task automatic test_ls1();
    exp_t e; logic [15:0] obs;
    do_rst();
    for (int c = 0; c < 2; c++) begin
      case (c)
        0: begin
          set_hit(1'b0, 1'b0);
          exp_ctrl(0, STALL, "ls1_hit_stall");
          exp_ctrl(1, STALL, "ls3_hit_stall");
        end
        default: begin
          set_idle();
          exp_ctrl(0, PASS, "ls1_release");
          exp_bc(0, 16'd1, "ls1_bubble_cnt");
          exp_ctrl(1, STALL, "ls3_second_bubble");
        end
      endcase
      #2;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        obs = e.is_bc ? obs_bc[e.dut] : {10'd0, obs_ctrl[e.dut]};
        n_vec++;
        if (obs !== e.val) begin
          n_err++;
          $display("FAIL %s: dut%0d observed %h expected %h", e.name, e.dut, obs, e.val);
        end
      end
      tick();
    end
  endtask

  task automatic test_ls3();
    exp_t e; logic [15:0] obs;
    do_rst();
    for (int c = 0; c < 4; c++) begin
      case (c)
        0: begin
          set_hit(1'b0, 1'b0);
          exp_ctrl(1, STALL, "ls3_T");
          exp_ctrl(2, STALL, "ls3zr_T");
        end
        1: begin
          set_idle();
          exp_ctrl(1, STALL, "ls3_T1");
          exp_ctrl(0, PASS, "ls1_T1");
        end
        2: begin
          exp_ctrl(1, STALL, "ls3_T2");
          exp_ctrl(2, STALL, "ls3zr_T2");
        end
        default: begin
          exp_ctrl(1, PASS, "ls3_T3_pass");
          exp_ctrl(2, PASS, "ls3zr_T3_pass");
          exp_bc(1, 16'd3, "ls3_bubble_cnt");
          exp_bc(2, 16'd3, "ls3zr_bubble_cnt");
          exp_bc(0, 16'd1, "ls1_bubble_cnt");
        end
      endcase
      #2;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        obs = e.is_bc ? obs_bc[e.dut] : {10'd0, obs_ctrl[e.dut]};
        n_vec++;
        if (obs !== e.val) begin
          n_err++;
          $display("FAIL %s: dut%0d observed %h expected %h", e.name, e.dut, obs, e.val);
        end
      end
      tick();
    end
  endtask

  task automatic test_fields();
    exp_t e; logic [15:0] obs;
    do_rst();
    for (int c = 0; c < 5; c++) begin
      case (c)
        0: begin
          set_in(4'd5, 1'b1, 4'd0, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0);
          for (int d = 0; d < 3; d++) exp_ctrl(d, PASS, "unused_rn2_pass");
        end
        1: begin
          set_in(4'd5, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0);
          for (int d = 0; d < 3; d++) exp_ctrl(d, PASS, "no_load_pass");
        end
        2: begin
          set_in(4'd0, 1'b1, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
          exp_ctrl(2, PASS, "zero_reg_en_pass");
          exp_ctrl(0, STALL, "zero_reg_dis_stall");
          exp_ctrl(1, STALL, "zero_reg_dis_stall_ls3");
        end
        3: begin
          set_in(4'd5, 1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0);
          exp_ctrl(0, STALL, "rn2_hit_stall");
          exp_ctrl(2, STALL, "rn2_hit_stall_zr");
        end
        default: begin
          set_in(4'd6, 1'b1, 4'd7, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0);
          exp_ctrl(0, PASS, "no_match_pass");
        end
      endcase
      #2;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        obs = e.is_bc ? obs_bc[e.dut] : {10'd0, obs_ctrl[e.dut]};
        n_vec++;
        if (obs !== e.val) begin
          n_err++;
          $display("FAIL %s: dut%0d observed %h expected %h", e.name, e.dut, obs, e.val);
        end
      end
      tick();
    end
  endtask

  task automatic test_freeze();
    exp_t e; logic [15:0] obs;
    do_rst();
    for (int c = 0; c < 7; c++) begin
      case (c)
        0: begin
          set_hit(1'b1, 1'b0);
          for (int d = 0; d < 3; d++) exp_ctrl(d, FREEZE, "busy_beats_hit");
        end
        1: begin
          set_hit(1'b0, 1'b0);
          exp_ctrl(1, STALL, "frz_T");
          exp_ctrl(0, STALL, "frz_T_ls1");
        end
        2: begin
          set_in(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
          exp_ctrl(1, FREEZE, "frz_T1");
          exp_ctrl(0, FREEZE, "frz_T1_ls1");
        end
        3: begin
          exp_ctrl(1, FREEZE, "frz_T2");
          exp_bc(1, 16'd1, "frz_no_bubble_count");
        end
        4: begin
          set_idle();
          exp_ctrl(1, STALL, "frz_T3");
        end
        5: exp_ctrl(1, STALL, "frz_T4");
        default: begin
          exp_ctrl(1, PASS, "frz_T5_pass");
          exp_bc(1, 16'd3, "frz_bubble_cnt");
          exp_bc(0, 16'd1, "frz_bubble_cnt_ls1");
        end
      endcase
      #2;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        obs = e.is_bc ? obs_bc[e.dut] : {10'd0, obs_ctrl[e.dut]};
        n_vec++;
        if (obs !== e.val) begin
          n_err++;
          $display("FAIL %s: dut%0d observed %h expected %h", e.name, e.dut, obs, e.val);
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    exp_t e; logic [15:0] obs;
    do_rst();
    for (int c = 0; c < 7; c++) begin
      if (c < 4) set_hit(1'b0, 1'b0);
      else set_idle();
      case (c)
        3: begin
          exp_ctrl(1, STALL, "b2b_rehit");
          exp_ctrl(0, STALL, "b2b_ls1_hold");
        end
        4: begin
          exp_ctrl(1, STALL, "b2b_T4");
          exp_ctrl(0, PASS, "b2b_ls1_release");
        end
        6: begin
          exp_ctrl(1, PASS, "b2b_release");
          exp_bc(1, 16'd6, "b2b_bubble_cnt");
          exp_bc(0, 16'd4, "b2b_bubble_cnt_ls1");
        end
        default: exp_ctrl(1, STALL, "b2b_stall");
      endcase
      #2;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        obs = e.is_bc ? obs_bc[e.dut] : {10'd0, obs_ctrl[e.dut]};
        n_vec++;
        if (obs !== e.val) begin
          n_err++;
          $display("FAIL %s: dut%0d observed %h expected %h", e.name, e.dut, obs, e.val);
        end
      end
      tick();
    end
  endtask

  task automatic test_branch();
    exp_t e; logic [15:0] obs;
    do_rst();
    for (int c = 0; c < 5; c++) begin
      case (c)
        0: begin
          set_hit(1'b0, 1'b1);
          for (int d = 0; d < 3; d++) exp_ctrl(d, FLUSH, "branch_beats_hit");
        end
        1: begin
          set_idle();
          for (int d = 0; d < 3; d++) begin
            exp_ctrl(d, PASS, "after_flush_pass");
            exp_bc(d, 16'd0, "flush_no_bubble");
          end
        end
        2: begin
          set_hit(1'b0, 1'b0);
          exp_ctrl(1, STALL, "br_enter_lstall");
        end
        3: begin
          set_in(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
          exp_ctrl(1, FLUSH, "branch_in_lstall");
          exp_ctrl(0, FLUSH, "branch_beats_busy");
        end
        default: begin
          set_idle();
          exp_ctrl(1, PASS, "after_lstall_flush");
          exp_bc(1, 16'd1, "br_bubble_cnt");
        end
      endcase
      #2;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        obs = e.is_bc ? obs_bc[e.dut] : {10'd0, obs_ctrl[e.dut]};
        n_vec++;
        if (obs !== e.val) begin
          n_err++;
          $display("FAIL %s: dut%0d observed %h expected %h", e.name, e.dut, obs, e.val);
        end
      end
      tick();
    end
  endtask

  task automatic test_rst_mid();
    exp_t e; logic [15:0] obs;
    do_rst();
    for (int c = 0; c < 7; c++) begin
      case (c)
        0: begin
          set_hit(1'b0, 1'b0);
          exp_ctrl(1, STALL, "rm_enter_lstall");
        end
        1: begin
          rst = 1'b1; set_hit(1'b0, 1'b0);
          for (int d = 0; d < 3; d++) exp_ctrl(d, PASS, "rst_mid_pass");
        end
        2: begin
          rst = 1'b0; set_idle();
          exp_ctrl(1, PASS, "rm_no_residual");
          exp_bc(1, 16'd0, "rm_bubble_cleared");
          exp_bc(0, 16'd0, "rm_bubble_cleared_ls1");
        end
        3: begin
          set_hit(1'b0, 1'b0);
          exp_ctrl(1, STALL, "rm_fresh_T");
        end
        4: begin
          set_idle();
          exp_ctrl(1, STALL, "rm_fresh_T1");
        end
        5: exp_ctrl(1, STALL, "rm_fresh_T2");
        default: begin
          exp_ctrl(1, PASS, "rm_fresh_pass");
          exp_bc(1, 16'd3, "rm_bubble_cnt");
        end
      endcase
      #2;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        obs = e.is_bc ? obs_bc[e.dut] : {10'd0, obs_ctrl[e.dut]};
        n_vec++;
        if (obs !== e.val) begin
          n_err++;
          $display("FAIL %s: dut%0d observed %h expected %h", e.name, e.dut, obs, e.val);
        end
      end
      tick();
    end
  endtask

  task automatic test_saturate();
    exp_t e; logic [15:0] obs;
    do_rst();
    set_hit(1'b0, 1'b0);
    for (int c = 0; c < 2; c++) begin
      case (c)
        0: begin
          repeat (65534) @(posedge clk);
          @(negedge clk);
          exp_bc(0, 16'hFFFE, "sat_below_max");
        end
        default: begin
          repeat (6) @(posedge clk);
          @(negedge clk);
          for (int d = 0; d < 3; d++) exp_bc(d, 16'hFFFF, "sat_hold_max");
          exp_ctrl(0, STALL, "sat_still_stalling");
        end
      endcase
      #2;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        obs = e.is_bc ? obs_bc[e.dut] : {10'd0, obs_ctrl[e.dut]};
        n_vec++;
        if (obs !== e.val) begin
          n_err++;
          $display("FAIL %s: dut%0d observed %h expected %h", e.name, e.dut, obs, e.val);
        end
      end
    end
    set_idle();
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    @(negedge clk);
    test_reset();
    test_ls1();
    test_ls3();
    test_fields();
    test_freeze();
    test_back_to_back();
    test_branch();
    test_rst_mid();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
